idli_mem_seq_m: RTL
===================

# idli_mem_seq_m

Memory-transfer sequencer for the idli core. It sits between decode and the SQI memory interface and expands every LD/ST/LDM/STM into an address period followed by one 4-GCK data period per register, from the first to the last register. It drives the register index and transfer enables into the register file / SQI path. It also stalls the frontend until the final register period is reached.

## Interface
Parameters: none.
- i_ms_gck  in  1  gated core clock; all state on posedge.
- i_ms_rst  in  1  asynchronous, active-high reset.
- i_ms_ctr  in  2  sync counter; a period spans ctr 0..3, and the period boundary is the posedge where ctr==3.
- i_ms_start  in  1  decoded instruction is a memory op; sampled only at a boundary.
- i_ms_first  in  4  first register (decode mem_first).
- i_ms_last  in  4  last register (decode mem_last).
- i_ms_op  in  1  0 = load (SQI to reg), 1 = store (reg to SQI).
- i_ms_hold  in  1  memory not ready; sampled only at a boundary.
- o_ms_busy  out  1  sequencer not IDLE.
- o_ms_stall  out  1  frontend must not accept a new instruction at the next boundary.
- o_ms_addr  out  1  current period is the address period.
- o_ms_reg  out  4  register being transferred in the current period.
- o_ms_ld_en  out  1  write o_ms_reg from SQI this period.
- o_ms_st_en  out  1  drive o_ms_reg onto SQI this period.
- o_ms_done  out  1  one-cycle pulse after the final data period.

## Operation
- States are IDLE, ADDR, XFER and BUBBLE. All transitions happen only at a boundary (ctr==3 edge); between boundaries the state and all outputs except o_ms_done are constant.
- IDLE: if i_ms_start=1, latch first, op and a count, then go to ADDR. Otherwise stay in IDLE.
- Count = ((last - first) mod 16) + 1, held in 5 bits with range 1..16. last < first wraps through 15 to 0. last == first transfers 1 register.
- ADDR: o_ms_addr=1. At the boundary, go to BUBBLE if i_ms_hold=1, otherwise to XFER.
- XFER: o_ms_reg = current index. o_ms_ld_en = ~op, o_ms_st_en = op. At the boundary:
  - if this is the final register, go to IDLE and assert o_ms_done;
  - else if i_ms_hold=1, go to BUBBLE;
  - else increment the index mod 16, decrement the remaining count, and stay in XFER.
- BUBBLE: enables are 0 and o_ms_reg holds the next register to transfer. At the boundary, stay in BUBBLE while i_ms_hold=1, otherwise go to XFER.
- Index and count advance only on leaving an XFER period, never on leaving a BUBBLE.
- i_ms_start is ignored unless the state is IDLE. The first/last/op inputs are ignored after they are latched.
- o_ms_stall = busy and not (XFER with remaining==1). The frontend therefore accepts the next instruction at the boundary that ends the final data period. A start at that same boundary is taken in the following IDLE period: no back-to-back overlap.
- Reset (any time, including mid-transfer): state IDLE, index 0, count 0. All outputs are 0: busy, stall, addr, reg, ld_en, st_en, done. Any partial transfer is abandoned.

## Timing
- Start accepted at boundary B0 → ADDR in the period after B0 → first XFER in the next period.
- Latency from accept to o_ms_done with no holds is (count + 1) periods, i.e. 4·(count+1) GCK cycles.
- o_ms_done is high for exactly one GCK cycle, the ctr==0 cycle after the last XFER boundary. It is registered.
- All outputs are registered or decoded from state flops only. There is no combinational path from any input to any output.
- A hold adds whole periods only. Each period with i_ms_hold=1 at its closing boundary inserts exactly one BUBBLE period.
- i_ms_ctr is trusted; the sequencer never resynchronises it.

## Test plan
- Single load: first=5, last=5, op=0, start at a boundary → ADDR for 1 period, then XFER with reg=5 and ld_en=1 for 1 period. done pulses at ctr==0 of the next period. stall is high only during the ADDR period.
- Multi store: first=2, last=6, op=1 → 5 XFER periods with reg 2,3,4,5,6 and st_en=1 throughout. ld_en is never high. done pulses 24 GCK cycles after accept.
- Wrap-around: first=14, last=1 → reg sequence 14,15,0,1 (count 4). A full range, first=3 and last=2, gives 16 periods ending at reg 2.
- Hold: first=0, last=2, with i_ms_hold=1 at the boundary ending the reg-0 period → one BUBBLE period (enables 0, reg=1), then reg 1 and reg 2. Two consecutive holds give two bubbles.
- Start while busy and back-to-back: a start pulse mid-transfer is ignored. A start at the final-XFER boundary is accepted at the first IDLE boundary after done.
- Async reset: assert i_ms_rst mid-XFER with ctr=1 → all outputs 0 immediately, without waiting for a clock edge. After release, a new start behaves as in the single-load case.

Source files
------------

// File: rtl/idli_mem_seq_m.sv
// idli_mem_seq_m: expands LD/ST/LDM/STM into an address period plus one data period per register.
module idli_mem_seq_m (
  input  logic       i_ms_gck,
  input  logic       i_ms_rst,
  input  logic [1:0] i_ms_ctr,
  input  logic       i_ms_start,
  input  logic [3:0] i_ms_first,
  input  logic [3:0] i_ms_last,
  input  logic       i_ms_op,
  input  logic       i_ms_hold,
  output logic       o_ms_busy,
  output logic       o_ms_stall,
  output logic       o_ms_addr,
  output logic [3:0] o_ms_reg,
  output logic       o_ms_ld_en,
  output logic       o_ms_st_en,
  output logic       o_ms_done
);
  typedef enum logic [1:0] {IDLE, ADDR, XFER, BUBBLE} state_t;
  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [4:0] cnt_q, cnt_d;
  logic       op_q, op_d;
  logic       done_q, done_d;
  logic       bnd, fin, xfer;
  assign bnd  = i_ms_ctr == 2'd3;
  assign fin  = cnt_q == 5'd1;
  assign xfer = state_q == XFER;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    done_d  = 1'b0;
    if (bnd) begin
      case (state_q)
        IDLE: if (i_ms_start) begin
          state_d = ADDR;
          idx_d   = i_ms_first;
          cnt_d   = {1'b0, i_ms_last - i_ms_first} + 5'd1;
          op_d    = i_ms_op;
        end
        ADDR: state_d = i_ms_hold ? BUBBLE : XFER;
        XFER: if (fin) begin
          state_d = IDLE;
          cnt_d   = 5'd0;
          done_d  = 1'b1;
        end else begin
          // index advances when leaving XFER, so a following bubble already shows the next register
          state_d = i_ms_hold ? BUBBLE : XFER;
          idx_d   = idx_q + 4'd1;
          cnt_d   = cnt_q - 5'd1;
        end
        default: state_d = i_ms_hold ? BUBBLE : XFER;
      endcase
    end
  end
  always_ff @(posedge i_ms_gck or posedge i_ms_rst) begin
    if (i_ms_rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 5'd0;
      op_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      done_q  <= done_d;
    end
  end
  assign o_ms_busy  = state_q != IDLE;
  assign o_ms_stall = o_ms_busy & ~(xfer & fin);
  assign o_ms_addr  = state_q == ADDR;
  assign o_ms_reg   = (xfer | state_q == BUBBLE) ? idx_q : 4'd0;
  assign o_ms_ld_en = xfer & ~op_q;
  assign o_ms_st_en = xfer & op_q;
  assign o_ms_done  = done_q;
endmodule
